// File: rtl/ws2812_rz_decoder.sv
// ws2812_rz_decoder
// Receive side of a WS2812 single-wire return-to-zero link. Each high pulse on
// din is timed in clk cycles. A pulse of BIT_THRESHOLD_CYCLES or more decodes
// as 1; a shorter pulse decodes as 0. Bits arrive MSB first in G, R, B order.
// Every 24 bits are reported as one pixel. A long low period is a latch and
// ends the frame.
//
// Optional feature: define WS2812_RX_FORWARD_EN to build the cascade forwarder.
// Pixel 0 of each frame is consumed. Later pixels are repeated on dout, which
// emulates a daisy-chained LED. Without the macro, dout is tied low.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   din          in   serial WS2812 line, asynchronous to clk
//   r, g, b      out  last decoded pixel (8 bits each)
//   pixel_valid  out  one-cycle pulse; r/g/b/pixel_index are valid while high
//   pixel_index  out  index of the reported pixel since the last latch
//   frame_end    out  one-cycle pulse when a latch low period is detected
//   err          out  one-cycle pulse on a protocol error
//   dout         out  cascade output (forwarder only, else 0)
module ws2812_rz_decoder #(
  parameter int unsigned BIT_THRESHOLD_CYCLES = 6,
  parameter int unsigned MAX_HIGH_CYCLES      = 20,
  parameter int unsigned RESET_CYCLES         = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       pixel_valid,
  output logic [9:0] pixel_index,
  output logic       frame_end,
  output logic       err,
  output logic       dout
);

  localparam int unsigned HcW = $clog2(MAX_HIGH_CYCLES + 1);
  localparam int unsigned LcW = $clog2(RESET_CYCLES + 1);

  localparam logic [HcW-1:0] HcMax = HcW'(MAX_HIGH_CYCLES);
  localparam logic [HcW-1:0] HcThr = HcW'(BIT_THRESHOLD_CYCLES);
  localparam logic [HcW-1:0] HcOne = HcW'(1);
  localparam logic [LcW-1:0] LcMax = LcW'(RESET_CYCLES);
  localparam logic [LcW-1:0] LcOne = LcW'(1);

  typedef enum logic [1:0] {
    StWaitReset,
    StIdle,
    StHigh,
    StLow
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizer plus one delay stage for edges
  // ---------------------------------------------------------------------------
  logic din_m, din_s, din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  logic rise, fall;
  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [HcW-1:0] hc_q, hc_d;
  logic [LcW-1:0] lc_q, lc_d;
  logic [4:0]     bc_q, bc_d;
  // Only 23 history bits are kept; the 24th bit is merged in when the word completes.
  logic [22:0]    sr_q, sr_d;
  logic [9:0]     pix_q, pix_d;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic [9:0]     idx_q, idx_d;
  logic           pv_q, pv_d, fe_q, fe_d, err_q, err_d;

  logic [HcW-1:0] hc_inc;
  logic           high_err;
  logic           bit_val;
  logic [23:0]    word;

  assign hc_inc   = hc_q + HcOne;
  // The pulse is still high and the count would reach the limit on this edge.
  assign high_err = (state_q == StHigh) && din_s && (hc_inc == HcMax);
  assign bit_val  = (hc_q >= HcThr);
  assign word     = {sr_q, bit_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitReset;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitReset: begin
        if (lc_q == LcMax) begin
          state_d = rise ? StHigh : StIdle;
        end
      end
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (high_err) begin
          state_d = StWaitReset;
        end else if (fall) begin
          state_d = StLow;
        end
      end
      StLow: begin
        // A rise on the same edge as the latch starts the next frame immediately.
        if (lc_q == LcMax) begin
          state_d = rise ? StHigh : StIdle;
        end else if (rise) begin
          state_d = StHigh;
        end
      end
      default: state_d = StWaitReset;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, shift register and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    hc_d  = hc_q;
    lc_d  = lc_q;
    bc_d  = bc_q;
    sr_d  = sr_q;
    pix_d = pix_q;
    r_d   = r_q;
    g_d   = g_q;
    b_d   = b_q;
    idx_d = idx_q;
    pv_d  = 1'b0;
    fe_d  = 1'b0;
    err_d = 1'b0;

    unique case (state_q)
      StWaitReset: begin
        bc_d = '0;
        hc_d = '0;
        if (lc_q == LcMax) begin
          lc_d = '0;
          hc_d = rise ? HcOne : '0;
        end else if (din_s) begin
          lc_d = '0;
        end else begin
          lc_d = lc_q + LcOne;
        end
      end
      StIdle: begin
        lc_d = '0;
        if (rise) begin
          hc_d = HcOne;
        end
      end
      StHigh: begin
        if (high_err) begin
          // Stuck-high line: drop the partial pixel and resynchronise on a latch.
          err_d = 1'b1;
          bc_d  = '0;
          pix_d = '0;
          hc_d  = '0;
          lc_d  = '0;
        end else if (fall) begin
          sr_d = word[22:0];
          hc_d = '0;
          lc_d = LcOne;
          if (bc_q == 5'd23) begin
            g_d   = word[23:16];
            r_d   = word[15:8];
            b_d   = word[7:0];
            idx_d = pix_q;
            pv_d  = 1'b1;
            pix_d = pix_q + 10'd1;
            bc_d  = '0;
          end else begin
            bc_d = bc_q + 5'd1;
          end
        end else if (hc_q != HcMax) begin
          hc_d = hc_inc;
        end
      end
      StLow: begin
        if (lc_q == LcMax) begin
          fe_d  = 1'b1;
          err_d = (bc_q != 5'd0);
          bc_d  = '0;
          pix_d = '0;
          lc_d  = '0;
          hc_d  = rise ? HcOne : '0;
        end else if (rise) begin
          hc_d = HcOne;
          lc_d = '0;
        end else begin
          lc_d = lc_q + LcOne;
        end
      end
      default: begin
        hc_d = '0;
        lc_d = '0;
        bc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q  <= '0;
      lc_q  <= '0;
      bc_q  <= '0;
      sr_q  <= '0;
      pix_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      pv_q  <= 1'b0;
      fe_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      lc_q  <= lc_d;
      bc_q  <= bc_d;
      sr_q  <= sr_d;
      pix_q <= pix_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      idx_q <= idx_d;
      pv_q  <= pv_d;
      fe_q  <= fe_d;
      err_q <= err_d;
    end
  end

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign pixel_index = idx_q;
  assign pixel_valid = pv_q;
  assign frame_end   = fe_q;
  assign err         = err_q;

  // ---------------------------------------------------------------------------
  // Cascade forwarder
  // ---------------------------------------------------------------------------
`ifdef WS2812_RX_FORWARD_EN
  logic fwd_q, dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      if (fe_d || err_d) begin
        fwd_q <= 1'b0;
      end else if (pv_d && (pix_q == 10'd0)) begin
        fwd_q <= 1'b1;
      end
      dout_q <= din_s & fwd_q;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rz_decoder.sv
module tb_ws2812_rz_decoder;

`ifdef WS2812_RX_FORWARD_EN
  localparam bit FwdBuild = 1'b1;
`else
  localparam bit FwdBuild = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] r, g, b;
  logic       pixel_valid;
  logic [9:0] pixel_index;
  logic       frame_end;
  logic       err;
  logic       dout;

  ws2812_rz_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .r           (r),
    .g           (g),
    .b           (b),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_end   (frame_end),
    .err         (err),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g, r, b;
    int         hi1, hi0, lo1, lo0;
    logic [7:0] eg, er, eb;
    int         eidx;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int rise_cyc = 0;

  // Event log filled by the monitor
  int pv_cnt = 0, fe_cnt = 0, err_cnt = 0;
  int pv_cyc = 0, fe_cyc = 0, err_cyc = 0;
  logic [7:0] pv_r = '0, pv_g = '0, pv_b = '0;
  logic [9:0] pv_idx = '0;

  // dout reference: din as sampled by the DUT, three edges deep
  logic [2:0] hist = '0;
  bit chk_dout = 1'b0;
  bit fwd_win = 1'b0;
  int dout_bad = 0;
  int dout_ones = 0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[1:0], din};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        pv_cnt = pv_cnt + 1;
        pv_cyc = cyc;
        pv_r = r;
        pv_g = g;
        pv_b = b;
        pv_idx = pixel_index;
      end
      if (frame_end) begin
        fe_cnt = fe_cnt + 1;
        fe_cyc = cyc;
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      if (chk_dout) begin
        if (dout !== ((FwdBuild && fwd_win) ? hist[2] : 1'b0)) dout_bad = dout_bad + 1;
        if (fwd_win && dout === 1'b1) dout_ones = dout_ones + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; din changes only at negedges.
  task automatic send_bit(input logic v, input int hi1, input int hi0, input int lo1,
                          input int lo0);
    din = 1'b1;
    repeat (v ? hi1 : hi0) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat (v ? lo1 : lo0) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w, input int nbits, input vec_t t);
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[23-i], t.hi1, t.hi0, t.lo1, t.lo0);
    end
  endtask

  task automatic send_pix(input vec_t v);
    send_word({v.g, v.r, v.b}, 24, v);
  endtask

  task automatic hold_low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pix(input string name, input vec_t v, input int pv0);
    check({name, "_count"}, 64'(pv_cnt - pv0), 64'd1);
    check({name, "_g"}, 64'(pv_g), 64'(v.eg));
    check({name, "_r"}, 64'(pv_r), 64'(v.er));
    check({name, "_b"}, 64'(pv_b), 64'(v.eb));
    check({name, "_index"}, 64'(pv_idx), 64'(v.eidx));
    check({name, "_latency"}, 64'(pv_cyc - last_fall), 64'd3);
  endtask

  int pv0, fe0, err0;

  initial begin
    // Standard timing, threshold edges, the longest legal high, minimum timings.
    vecs[0] = '{8'h12, 8'h34, 8'h56, 8, 4, 4, 8, 8'h12, 8'h34, 8'h56, 0};
    vecs[1] = '{8'hAA, 8'h55, 8'h0F, 6, 5, 6, 6, 8'hAA, 8'h55, 8'h0F, 1};
    vecs[2] = '{8'hAA, 8'h55, 8'h0F, 5, 5, 6, 6, 8'h00, 8'h00, 8'h00, 2};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 19, 1, 1, 1, 8'hFF, 8'h00, 8'hFF, 3};
    vecs[4] = '{8'h80, 8'h01, 8'hC3, 8, 4, 1, 1, 8'h80, 8'h01, 8'hC3, 4};

    din = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({r, g, b, pixel_valid, pixel_index, frame_end, err, dout}),
          64'd0);
    rst_n = 1'b1;
    hold_low(500);

    for (int i = 0; i < 5; i++) begin
      pv0 = pv_cnt;
      send_pix(vecs[i]);
      hold_low(5);
      check_pix($sformatf("vec%0d", i), vecs[i], pv0);
    end
    check("no_err_in_vectors", 64'(err_cnt), 64'd0);

    // Latch after the frame: exactly one frame_end, 503 cycles after the last fall.
    fe0 = fe_cnt;
    err0 = err_cnt;
    hold_low(510);
    check("latch_frame_end_count", 64'(fe_cnt - fe0), 64'd1);
    check("latch_frame_end_latency", 64'(fe_cyc - last_fall), 64'd503);
    check("latch_no_err", 64'(err_cnt - err0), 64'd0);
    pv0 = pv_cnt;
    send_pix(vecs[0]);
    hold_low(5);
    check_pix("after_latch", vecs[0], pv0);

    // 12 bits then a latch: err with frame_end in the same cycle, no pixel.
    hold_low(510);
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    err0 = err_cnt;
    send_word(24'hA5C000, 12, vecs[0]);
    hold_low(510);
    check("partial_no_pixel", 64'(pv_cnt - pv0), 64'd0);
    check("partial_frame_end", 64'(fe_cnt - fe0), 64'd1);
    check("partial_err", 64'(err_cnt - err0), 64'd1);
    check("partial_fe_latency", 64'(fe_cyc - last_fall), 64'd503);
    check("partial_err_latency", 64'(err_cyc - last_fall), 64'd503);
    pv0 = pv_cnt;
    send_pix(vecs[0]);
    hold_low(5);
    check_pix("after_partial", vecs[0], pv0);

    // Stuck-high line: err, bits ignored until a full latch, which reports no frame_end.
    hold_low(20);
    err0 = err_cnt;
    fe0 = fe_cnt;
    din = 1'b1;
    rise_cyc = cyc;
    repeat (20) @(negedge clk);
    hold_low(4);
    check("stuck_err", 64'(err_cnt - err0), 64'd1);
    check("stuck_err_latency", 64'(err_cyc - rise_cyc), 64'd22);
    pv0 = pv_cnt;
    send_pix(vecs[0]);
    hold_low(510);
    check("stuck_bits_ignored", 64'(pv_cnt - pv0), 64'd0);
    check("stuck_no_frame_end", 64'(fe_cnt - fe0), 64'd0);
    pv0 = pv_cnt;
    send_pix(vecs[1]);
    hold_low(5);
    check_pix("after_stuck", '{8'hAA, 8'h55, 8'h0F, 6, 5, 6, 6, 8'hAA, 8'h55, 8'h0F, 0},
              pv0);

    // Cascade: pixel 0 is consumed, pixel 1 is repeated on dout.
    hold_low(510);
    chk_dout = 1'b1;
    send_pix(vecs[0]);
    fwd_win = 1'b1;
    pv0 = pv_cnt;
    send_pix(vecs[4]);
    hold_low(6);
    fwd_win = 1'b0;
    check_pix("cascade_pix1", '{8'h80, 8'h01, 8'hC3, 8, 4, 1, 1, 8'h80, 8'h01, 8'hC3, 1},
              pv0);
    hold_low(510);
    check("dout_track", 64'(dout_bad), 64'd0);
    check("dout_active", 64'(dout_ones > 0), 64'(FwdBuild));

    // Asynchronous reset in the middle of a pixel clears outputs before any edge.
    send_word(24'hFFFFFF, 10, vecs[0]);
    din = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             64'({r, g, b, pixel_valid, pixel_index, frame_end, err, dout}), 64'd0);
    din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_outputs",
          64'({r, g, b, pixel_valid, pixel_index, frame_end, err, dout}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rz_decoder.md
# ws2812_rz_decoder

Receive-side counterpart of the WS2812 transmit path. Samples a single-wire unipolar return-to-zero WS2812 stream and measures each high pulse to recover bits. Reassembles the bits into 24-bit GRB words and presents them as 8-bit r/g/b pixels with an index. Detects the latch (reset) low period and flags malformed traffic. Used as a loopback checker for the transmitter and as the front end of a cascaded-pixel emulator.

## Interface
- `BIT_THRESHOLD_CYCLES`, default 6: a high pulse of at least this many clk cycles decodes as 1; a shorter one decodes as 0. The defaults assume a 10 MHz clk: T0H 4 cycles, T1H 8 cycles.
- `MAX_HIGH_CYCLES`, default 20: a high pulse that reaches this length is an error.
- `RESET_CYCLES`, default 500: a low time that reaches this length is a latch (50 µs).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial WS2812 line, asynchronous to clk.
- `r`, `g`, `b`  out  8 each  last decoded pixel.
- `pixel_valid`  out  1  one-cycle pulse; r/g/b/pixel_index are valid while it is high.
- `pixel_index`  out  10  index of the reported pixel since the last latch; wraps 1023→0.
- `frame_end`  out  1  one-cycle pulse when a latch is detected.
- `err`  out  1  one-cycle pulse on a protocol error.
- `dout`  out  1  cascade output (see Configuration).

## Operation
- Input conditioning:
  - `din` passes through a 2-FF synchronizer to give `din_s`. A further register gives `din_d`.
  - rise = `din_s & ~din_d`; fall = `~din_s & din_d`.
- Wire format: 24 bits, MSB first, in the order G7..G0, R7..R0, B7..B0.
- Counters:
  - The high counter is sized $clog2(MAX_HIGH_CYCLES+1) and saturates.
  - The low counter is sized $clog2(RESET_CYCLES+1) and saturates.
  - The bit counter is 5 bits, range 0..23.
- FSM states:
  - WAIT_RESET: entered on reset and after any error.
    - Counts consecutive `din_s` low cycles; a rise clears the count.
    - Count == RESET_CYCLES → IDLE. No frame_end is issued.
  - IDLE: waits for a rise → HIGH, with high count = 1.
  - HIGH: high count increments each cycle while `din_s` is high.
    - On a fall: bit = (high count ≥ BIT_THRESHOLD_CYCLES). The bit shifts into the 24-bit register and the bit counter increments. Then → LOW with low count = 1.
    - On the 24th bit: register r/g/b, pulse pixel_valid, and present pixel_index. The pixel counter increments after the pulse and the bit counter returns to 0.
    - High count reaching MAX_HIGH_CYCLES: pulse err, discard the partial pixel, → WAIT_RESET.
  - LOW: low count increments each cycle while low.
    - A rise → HIGH with high count = 1.
    - Low count == RESET_CYCLES: pulse frame_end and clear the pixel counter → IDLE.
    - If the bit counter is nonzero at that point, err pulses in the same cycle and the partial bits are dropped.
- In IDLE, an indefinitely low line produces no further frame_end.
- Reset values: r=g=b=0, pixel_valid=0, pixel_index=0, frame_end=0, err=0, dout=0. The FSM resets to WAIT_RESET and all counters to 0.
- Asserting rst_n mid-frame clears all state immediately, without waiting for a clk edge.

## Timing
- All outputs are registered.
- A `din` edge at clk edge k is acted on by the FSM at edge k+2. Outputs change at k+2 and are observable in the following cycle.
- Latency is 3 clk cycles throughout:
  - Fall of the 24th bit → pixel_valid high.
  - Fall of the last bit + RESET_CYCLES low cycles → frame_end high.
- A synchronous high pulse of N cycles on `din` measures as high count N.
- Minimum supported low time between bits is 1 cycle; minimum high time is 1 cycle.
- pixel_valid, frame_end and err are each exactly one cycle wide. frame_end and err may coincide; pixel_valid and frame_end never coincide.

## Configuration
- `WS2812_RX_FORWARD_EN` defined:
  - A forward_active flag is set at the edge where pixel 0 completes. It is cleared on frame_end, on err, or on reset.
  - Register `dout <= din_s & forward_active`. Pixel 1 onward therefore appears on `dout`, delayed 3 cycles relative to `din`, emulating a daisy-chained LED.
  - Decoding of all pixels continues unchanged.
- Not defined: `dout` is held 0 and no forwarding logic is built.

## Test plan
- Release rst_n, hold din low for 500 cycles, then send G=0x12 R=0x34 B=0x56 (1 = 8H/4L, 0 = 4H/8L) → exactly one pixel_valid pulse with r=0x34, g=0x12, b=0x56, pixel_index=0, 3 cycles after the last fall.
- Send two pixels, then 500 low cycles → pixel_index 0 then 1. frame_end pulses once, 503 cycles after the final fall; no err. A following pixel reports index 0.
- Threshold: high pulses of 5 and 6 cycles → decoded as 0 and 1 respectively. Send 0xAA,0x55,0x0F with those widths and check the decoded bytes.
- Send 12 bits, then 500 low → err and frame_end in the same cycle, no pixel_valid. The next full pixel decodes correctly with index 0.
- Hold din high for 20 cycles → err pulse. Subsequent bits are ignored until 500 low cycles; then no frame_end, and the next pixel decodes.
- With WS2812_RX_FORWARD_EN, send 2 pixels then a latch → dout stays 0 during pixel 0, copies din with a 3-cycle delay during pixel 1, and is 0 after frame_end. Assert rst_n mid-pixel → all outputs read 0 immediately.
